// File: rtl/mem_arbiter.sv
// Three-way arbiter putting i-read, d-read and d-write requests onto one SDRAM controller port.
// Optional feature: define MEM_ARB_ROUND_ROBIN_EN to alternate I side and D side grants.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ir_go_i,
  input  logic [ADDR_WIDTH-1:0] ir_base_i,
  input  logic [ADDR_WIDTH-1:0] ir_length_i,
  input  logic                  dr_go_i,
  input  logic [ADDR_WIDTH-1:0] dr_base_i,
  input  logic [ADDR_WIDTH-1:0] dr_length_i,
  input  logic                  dw_go_i,
  input  logic [ADDR_WIDTH-1:0] dw_base_i,
  input  logic [ADDR_WIDTH-1:0] dw_length_i,
  output logic                  ir_done_o,
  output logic                  dr_done_o,
  output logic                  dw_done_o,
  output logic                  ir_available_o,
  output logic                  dr_available_o,
  output logic [DATA_WIDTH-1:0] ir_data_o,
  output logic [DATA_WIDTH-1:0] dr_data_o,
  input  logic                  ir_re_i,
  input  logic                  dr_re_i,
  input  logic                  dw_we_i,
  input  logic [DATA_WIDTH-1:0] dw_data_i,
  output logic                  dw_full_o,
  output logic                  m_go_o,
  output logic [ADDR_WIDTH-1:0] m_base_o,
  output logic [ADDR_WIDTH-1:0] m_length_o,
  output logic                  m_write_o,
  input  logic                  m_done_i,
  input  logic                  m_rd_available_i,
  input  logic [DATA_WIDTH-1:0] m_rd_data_i,
  output logic                  m_rd_re_o,
  output logic                  m_wr_we_o,
  output logic [DATA_WIDTH-1:0] m_wr_data_o,
  input  logic                  m_wr_full_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_BUSY  = 2'd3
  } state_e;

  // Grant codes double as the index of the requester slot.
  localparam logic [1:0] GR_IR = 2'd0;
  localparam logic [1:0] GR_DR = 2'd1;
  localparam logic [1:0] GR_DW = 2'd2;

  state_e                state_q, state_d;
  logic [2:0]            pend_q, pend_d;
  logic [ADDR_WIDTH-1:0] base_q [3];
  logic [ADDR_WIDTH-1:0] base_d [3];
  logic [ADDR_WIDTH-1:0] len_q [3];
  logic [ADDR_WIDTH-1:0] len_d [3];
  logic [1:0]            grant_q, grant_d, pick_s;
  logic                  m_go_q, m_go_d, m_write_q, m_write_d;
  logic [ADDR_WIDTH-1:0] m_base_q, m_base_d, m_length_q, m_length_d;
  logic [2:0]            go_s;
  logic [ADDR_WIDTH-1:0] req_base_s [3];
  logic [ADDR_WIDTH-1:0] req_len_s [3];
  logic                  rd_active_s;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic                  rr_q, rr_d;
`endif

  function automatic logic [2:0] grant_mask(input logic [1:0] g);
    case (g)
      GR_IR:   return 3'b001;
      GR_DR:   return 3'b010;
      GR_DW:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign go_s          = {dw_go_i, dr_go_i, ir_go_i};
  assign req_base_s[0] = ir_base_i;
  assign req_base_s[1] = dr_base_i;
  assign req_base_s[2] = dw_base_i;
  assign req_len_s[0]  = ir_length_i;
  assign req_len_s[1]  = dr_length_i;
  assign req_len_s[2]  = dw_length_i;

  // Winner among pending slots; write-back goes before refill on the D side.
  always_comb begin
    pick_s = GR_IR;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    // rr_q = 0 favours the I side, 1 favours the D side
    if (pend_q[0] && (!(pend_q[1] || pend_q[2]) || !rr_q)) begin
      pick_s = GR_IR;
    end else if (pend_q[2]) begin
      pick_s = GR_DW;
    end else if (pend_q[1]) begin
      pick_s = GR_DR;
    end else begin
      pick_s = GR_IR;
    end
`else
    if (pend_q[2]) begin
      pick_s = GR_DW;
    end else if (pend_q[1]) begin
      pick_s = GR_DR;
    end else begin
      pick_s = GR_IR;
    end
`endif
  end

  // Next-state, request capture and controller command generation.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    base_d     = base_q;
    len_d      = len_q;
    grant_d    = grant_q;
    m_go_d     = 1'b0;
    m_base_d   = m_base_q;
    m_length_d = m_length_q;
    m_write_d  = m_write_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d       = rr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pend_q != 3'b000) begin
          grant_d    = pick_s;
          m_base_d   = base_q[pick_s];
          m_length_d = len_q[pick_s];
          m_write_d  = (pick_s == GR_DW);
          m_go_d     = 1'b1;
          state_d    = ST_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_d       = (pick_s == GR_IR);
`endif
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      // m_done may still show the previous idle level here
      ST_WAIT:  state_d = ST_BUSY;
      ST_BUSY: begin
        if (m_done_i) begin
          pend_d  = pend_q & ~grant_mask(grant_q);
          state_d = ST_IDLE;
        end else begin
          state_d = ST_BUSY;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Captured after the retire clear so a colliding go re-arms the slot.
    for (int i = 0; i < 3; i++) begin
      if (go_s[i] && !pend_d[i]) begin
        pend_d[i] = 1'b1;
        base_d[i] = req_base_s[i];
        len_d[i]  = req_len_s[i];
      end else begin
        pend_d[i] = pend_d[i];
      end
    end
  end

  // State and request registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      pend_q     <= 3'b000;
      grant_q    <= GR_IR;
      m_go_q     <= 1'b0;
      m_write_q  <= 1'b0;
      m_base_q   <= {ADDR_WIDTH{1'b0}};
      m_length_q <= {ADDR_WIDTH{1'b0}};
      for (int i = 0; i < 3; i++) begin
        base_q[i] <= {ADDR_WIDTH{1'b0}};
        len_q[i]  <= {ADDR_WIDTH{1'b0}};
      end
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q       <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      grant_q    <= grant_d;
      m_go_q     <= m_go_d;
      m_write_q  <= m_write_d;
      m_base_q   <= m_base_d;
      m_length_q <= m_length_d;
      base_q     <= base_d;
      len_q      <= len_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q       <= rr_d;
`endif
    end
  end

  assign ir_done_o  = ~pend_q[0];
  assign dr_done_o  = ~pend_q[1];
  assign dw_done_o  = ~pend_q[2];
  assign m_go_o     = m_go_q;
  assign m_base_o   = m_base_q;
  assign m_length_o = m_length_q;
  assign m_write_o  = m_write_q;

  assign rd_active_s    = (state_q != ST_IDLE);
  assign ir_available_o = rd_active_s && (grant_q == GR_IR) && m_rd_available_i;
  assign dr_available_o = rd_active_s && (grant_q == GR_DR) && m_rd_available_i;
  assign m_rd_re_o      = rd_active_s && (((grant_q == GR_IR) && ir_re_i) ||
                                          ((grant_q == GR_DR) && dr_re_i));
  assign ir_data_o      = m_rd_data_i;
  assign dr_data_o      = m_rd_data_i;

  assign m_wr_we_o   = dw_we_i;
  assign m_wr_data_o = dw_data_i;
  assign dw_full_o   = m_wr_full_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// checked against a request-level reference model and a simple controller model.
module tb_mem_arbiter;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic ir_go, dr_go, dw_go;
  logic [31:0] ir_base, ir_length, dr_base, dr_length, dw_base, dw_length;
  logic ir_done, dr_done, dw_done, ir_available, dr_available;
  logic [31:0] ir_data, dr_data;
  logic ir_re, dr_re, dw_we;
  logic [31:0] dw_data;
  logic dw_full, m_go, m_write;
  logic [31:0] m_base, m_length;
  logic m_done = 1'b1;
  logic m_rd_available, m_rd_re, m_wr_we, m_wr_full;
  logic [31:0] m_rd_data, m_wr_data;

  mem_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk), .rst_i(rst),
    .ir_go_i(ir_go), .ir_base_i(ir_base), .ir_length_i(ir_length),
    .dr_go_i(dr_go), .dr_base_i(dr_base), .dr_length_i(dr_length),
    .dw_go_i(dw_go), .dw_base_i(dw_base), .dw_length_i(dw_length),
    .ir_done_o(ir_done), .dr_done_o(dr_done), .dw_done_o(dw_done),
    .ir_available_o(ir_available), .dr_available_o(dr_available),
    .ir_data_o(ir_data), .dr_data_o(dr_data),
    .ir_re_i(ir_re), .dr_re_i(dr_re), .dw_we_i(dw_we), .dw_data_i(dw_data),
    .dw_full_o(dw_full),
    .m_go_o(m_go), .m_base_o(m_base), .m_length_o(m_length), .m_write_o(m_write),
    .m_done_i(m_done), .m_rd_available_i(m_rd_available), .m_rd_data_i(m_rd_data),
    .m_rd_re_o(m_rd_re), .m_wr_we_o(m_wr_we), .m_wr_data_o(m_wr_data),
    .m_wr_full_i(m_wr_full)
  );

  function automatic int nwords(input logic [31:0] len);
    return int'((len + 32'd3) / 32'd4);
  endfunction

  function automatic logic [31:0] word_of(input logic [31:0] b, input int i);
    return (b + 32'(i * 4)) ^ 32'h5A5A_0000;
  endfunction

  // ---------------- controller model ----------------
  logic [31:0] fifo [0:63];
  int wr_p = 0, rd_p = 0, cnt = 0, ctl_delay = 20;
  assign m_rd_available = (wr_p != rd_p);
  assign m_rd_data      = fifo[rd_p % 64];

  always @(posedge clk) begin
    if (rst) begin
      wr_p <= 0; rd_p <= 0; cnt <= 0; m_done <= 1'b1;
    end else begin
      if (m_rd_re && m_rd_available) rd_p <= rd_p + 1;
      if (m_go) begin
        m_done <= 1'b0;
        cnt    <= ctl_delay;
        if (!m_write) begin
          for (int i = 0; i < nwords(m_length); i++) fifo[(wr_p + i) % 64] <= word_of(m_base, i);
          wr_p <= wr_p + nwords(m_length);
        end
      end else if (cnt > 0) begin
        cnt <= cnt - 1;
      end else if (!m_done && (wr_p == rd_p)) begin
        m_done <= 1'b1;
      end
    end
  end

  // ---------------- reference model ----------------
  int n_assert = 0, n_fail = 0;
  int cyc = 0;
  bit [2:0] pend = 3'b000;
  logic [31:0] mb [3];
  logic [31:0] ml [3];
  bit busy = 1'b0, exp_go = 1'b0, rr = 1'b0;
  int gsel = 0, issue_cyc = 0;
  logic [31:0] exp_ir_q[$], exp_dr_q[$];
  logic [31:0] obs_base_q[$], obs_len_q[$], wr_fwd_q[$];
  bit obs_wr_q[$];
  int obs_cyc_q[$];
  int ir_words = 0, dr_words = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input bit [2:0] p);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    if (p[0] && (!(p[1] || p[2]) || !rr)) return 0;
`endif
    if (p[2]) return 2;
    if (p[1]) return 1;
    return 0;
  endfunction

  task automatic step();
    bit [2:0] g, pp, clr;
    bit md, rs;
    logic [31:0] b [3];
    logic [31:0] l [3];
    #1;
    chk("ir_available", ir_available, 32'(busy && gsel == 0 && m_rd_available));
    chk("dr_available", dr_available, 32'(busy && gsel == 1 && m_rd_available));
    if (ir_available && ir_re) begin
      ir_words++;
      if (exp_ir_q.size() == 0) chk("ir_unexpected_word", 32'(exp_ir_q.size()), 32'd1);
      else chk("ir_data", ir_data, exp_ir_q.pop_front());
    end
    if (dr_available && dr_re) begin
      dr_words++;
      if (exp_dr_q.size() == 0) chk("dr_unexpected_word", 32'(exp_dr_q.size()), 32'd1);
      else chk("dr_data", dr_data, exp_dr_q.pop_front());
    end
    chk("m_wr_we", m_wr_we, dw_we);
    chk("m_wr_data", m_wr_data, dw_data);
    chk("dw_full", dw_full, m_wr_full);
    if (m_wr_we) wr_fwd_q.push_back(m_wr_data);
    g = {dw_go, dr_go, ir_go}; md = m_done; rs = rst;
    b[0] = ir_base; b[1] = dr_base; b[2] = dw_base;
    l[0] = ir_length; l[1] = dr_length; l[2] = dw_length;
    @(negedge clk);
    cyc++;
    exp_go = 1'b0;
    if (rs) begin
      pend = 3'b000; busy = 1'b0; rr = 1'b0;
      exp_ir_q.delete(); exp_dr_q.delete();
    end else begin
      pp = pend; clr = 3'b000;
      if (busy) begin
        if (md && (cyc - 1 >= issue_cyc + 2)) begin clr[gsel] = 1'b1; busy = 1'b0; end
      end else if (pp != 3'b000) begin
        gsel = pick(pp); busy = 1'b1; issue_cyc = cyc; exp_go = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        rr = (gsel == 0);
`endif
        for (int i = 0; i < nwords(ml[gsel]); i++) begin
          if (gsel == 0) exp_ir_q.push_back(word_of(mb[gsel], i));
          if (gsel == 1) exp_dr_q.push_back(word_of(mb[gsel], i));
        end
      end
      for (int r = 0; r < 3; r++) begin
        if (g[r] && (!pp[r] || clr[r])) begin mb[r] = b[r]; ml[r] = l[r]; end
        pend[r] = g[r] ? 1'b1 : (pp[r] & ~clr[r]);
      end
    end
    chk("m_go", m_go, 32'(exp_go));
    if (exp_go) begin
      chk("m_base", m_base, mb[gsel]);
      chk("m_length", m_length, ml[gsel]);
      chk("m_write", m_write, 32'(gsel == 2));
    end
    chk("ir_done", ir_done, 32'(!pend[0]));
    chk("dr_done", dr_done, 32'(!pend[1]));
    chk("dw_done", dw_done, 32'(!pend[2]));
    if (m_go) begin
      obs_base_q.push_back(m_base); obs_len_q.push_back(m_length);
      obs_wr_q.push_back(m_write);  obs_cyc_q.push_back(cyc);
    end
  endtask

  task automatic drain(input int maxc);
    int n = 0;
    while ((pend != 3'b000 || busy || exp_ir_q.size() != 0 || exp_dr_q.size() != 0) && n < maxc) begin
      step(); n++;
    end
    if (n >= maxc) begin
      n_assert++; n_fail++;
      $error("FAIL drain_timeout: observed %0d cycles expected fewer than %0d", n, maxc);
    end
    step(); step();
  endtask

  task automatic clear_logs();
    obs_base_q.delete(); obs_len_q.delete(); obs_wr_q.delete(); obs_cyc_q.delete();
    wr_fwd_q.delete(); ir_words = 0; dr_words = 0;
  endtask

  initial begin
    int n0;
    rst = 1'b1; ir_go = 1'b0; dr_go = 1'b0; dw_go = 1'b0;
    ir_base = 32'h0; ir_length = 32'h0; dr_base = 32'h0; dr_length = 32'h0;
    dw_base = 32'h0; dw_length = 32'h0;
    ir_re = 1'b1; dr_re = 1'b1; dw_we = 1'b0; dw_data = 32'h0; m_wr_full = 1'b0;
    @(negedge clk);
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_m_base", m_base, 32'h0);
    chk("reset_m_length", m_length, 32'h0);
    chk("reset_m_write", m_write, 32'h0);

    // single i-read
    clear_logs(); n0 = cyc;
    ir_go = 1'b1; ir_base = 32'h100; ir_length = 32'd32;
    step(); ir_go = 1'b0;
    drain(200);
    chk("single_issue_count", 32'(obs_cyc_q.size()), 32'd1);
    chk("single_latency", 32'(obs_cyc_q[0]), 32'(n0 + 2));
    chk("single_base", obs_base_q[0], 32'h100);
    chk("single_write", 32'(obs_wr_q[0]), 32'd0);
    chk("single_ir_words", 32'(ir_words), 32'd8);
    chk("single_dr_words", 32'(dr_words), 32'd0);

    // simultaneous requests
    clear_logs(); ctl_delay = 6;
    ir_go = 1'b1; ir_base = 32'h1000; ir_length = 32'd16;
    dr_go = 1'b1; dr_base = 32'h2000; dr_length = 32'd16;
    dw_go = 1'b1; dw_base = 32'h3000; dw_length = 32'd16;
    step(); ir_go = 1'b0; dr_go = 1'b0; dw_go = 1'b0;
    drain(300);
    chk("simul_count", 32'(obs_base_q.size()), 32'd3);
    chk("simul_first", obs_base_q[0], 32'h3000);
    chk("simul_first_write", 32'(obs_wr_q[0]), 32'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
    chk("simul_second", obs_base_q[1], 32'h1000);
    chk("simul_third", obs_base_q[2], 32'h2000);
`else
    chk("simul_second", obs_base_q[1], 32'h2000);
    chk("simul_third", obs_base_q[2], 32'h1000);
`endif

    // write burst before dw_go with back-pressure
    clear_logs();
    for (int i = 0; i < 10; i++) begin
      dw_we = (i < 8); dw_data = 32'hD000_0000 + 32'(i * 17);
      m_wr_full = (i >= 2 && i < 5);
      step();
    end
    dw_we = 1'b0; m_wr_full = 1'b0;
    chk("burst_count", 32'(wr_fwd_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk("burst_word", wr_fwd_q[i], 32'hD000_0000 + 32'(i * 17));
    dw_go = 1'b1; dw_base = 32'h4000; dw_length = 32'd32;
    step(); dw_go = 1'b0;
    drain(200);
    chk("burst_write_issue", 32'(obs_wr_q[0]), 32'd1);

    // duplicate dr_go while pending
    clear_logs();
    dr_go = 1'b1; dr_base = 32'h200; dr_length = 32'd8;
    step(); dr_base = 32'h300;
    step(); dr_go = 1'b0;
    drain(200);
    chk("dup_count", 32'(obs_base_q.size()), 32'd1);
    chk("dup_base", obs_base_q[0], 32'h200);

    // zero length
    clear_logs();
    ir_go = 1'b1; ir_base = 32'h500; ir_length = 32'd0;
    step(); ir_go = 1'b0;
    drain(200);
    chk("zero_len", obs_len_q[0], 32'd0);
    chk("zero_words", 32'(ir_words), 32'd0);

    // reset while busy
    ctl_delay = 30;
    ir_go = 1'b1; ir_base = 32'h600; ir_length = 32'd16;
    step(); ir_go = 1'b0;
    for (int i = 0; i < 6; i++) step();
    rst = 1'b1; step(); rst = 1'b0;
    chk("rst_ir_done", ir_done, 32'd1);
    chk("rst_m_go", m_go, 32'd0);
    clear_logs(); ctl_delay = 5; n0 = cyc;
    ir_go = 1'b1; ir_base = 32'h700; ir_length = 32'd8;
    step(); ir_go = 1'b0;
    drain(200);
    chk("post_rst_latency", 32'(obs_cyc_q[0]), 32'(n0 + 2));
    chk("post_rst_base", obs_base_q[0], 32'h700);

    // random traffic
    for (int c = 0; c < 600; c++) begin
      ctl_delay = $urandom_range(2, 12);
      ir_go = ir_done && ($urandom_range(0, 3) == 0);
      dr_go = dr_done && ($urandom_range(0, 3) == 0);
      dw_go = dw_done && ($urandom_range(0, 3) == 0);
      ir_base = $urandom & 32'h0000_FFFC; ir_length = 32'($urandom_range(0, 16) * 4);
      dr_base = $urandom & 32'h0000_FFFC; dr_length = 32'($urandom_range(0, 16) * 4);
      dw_base = $urandom & 32'h0000_FFFC; dw_length = 32'($urandom_range(0, 16) * 4);
      ir_re = 1'($urandom); dr_re = 1'($urandom);
      dw_we = 1'($urandom); dw_data = $urandom; m_wr_full = 1'($urandom);
      step();
    end
    ir_go = 1'b0; dr_go = 1'b0; dw_go = 1'b0; ir_re = 1'b1; dr_re = 1'b1;
    drain(1000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
